// File: rtl/vending_pkg.sv
// vending_pkg
// Shared definitions for the change dispenser and the coin acceptor:
// coin codes, coin values in cents, and the dispenser state encoding.
// Both FSMs import this so the code map stays identical across them.
package vending_pkg;

  // Dispenser controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PRESENT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Coin codes on the mechanism interface
  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_5    = 3'd1;
  localparam logic [2:0] COIN_10   = 3'd2;
  localparam logic [2:0] COIN_25   = 3'd3;

  // Coin values in cents
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_25 = 8'd25;

  // Value in cents of a coin code; unknown codes are worth nothing
  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5:  return VAL_5;
      COIN_10: return VAL_10;
      COIN_25: return VAL_25;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// coin_inventory
// Per-denomination coin counters (5c, 10c, 25c) with refill and decrement.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   refill_valid/code   - add one coin of refill_code (codes 0 and 4-7 ignored)
//   dec_valid/code      - remove one coin of dec_code (a coin was ejected)
//   empty_5/10/25       - denomination count is zero
// Counters saturate at INV_MAX and never drop below zero. A refill and a
// decrement of the same denomination in one cycle cancel out.
module coin_inventory
  import vending_pkg::*;
#(
  parameter logic [3:0] INV_INIT = 4'd15,
  parameter logic [3:0] INV_MAX  = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refill_valid,
  input  logic [2:0] refill_code,
  input  logic       dec_valid,
  input  logic [2:0] dec_code,
  output logic       empty_5,
  output logic       empty_10,
  output logic       empty_25
);

  // Slot 0 holds 5c, slot 1 holds 10c, slot 2 holds 25c
  localparam logic [2:0] SLOT_CODE [3] = '{COIN_5, COIN_10, COIN_25};

  logic [2:0][3:0] cnt_q, cnt_d;
  logic [2:0]      inc_hit, dec_hit;

  always_comb begin
    cnt_d   = cnt_q;
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 0; i < 3; i++) begin
      inc_hit[i] = refill_valid && (refill_code == SLOT_CODE[i]);
      dec_hit[i] = dec_valid && (dec_code == SLOT_CODE[i]);
      if (inc_hit[i] && !dec_hit[i] && (cnt_q[i] < INV_MAX)) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec_hit[i] && !inc_hit[i] && (cnt_q[i] != 4'd0)) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= INV_INIT;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign empty_5  = (cnt_q[0] == 4'd0);
  assign empty_10 = (cnt_q[1] == 4'd0);
  assign empty_25 = (cnt_q[2] == 4'd0);

endmodule

// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser
// Pays out change greedily (25c, 10c, 5c) from a local coin inventory.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_amount  - change request in cents, taken while req_ready=1
//   req_ready             - high only in IDLE
//   coin_valid/coin_out   - coin presented to the mechanism, held until coin_ack
//   coin_ack              - mechanism ejected the presented coin
//   refill_valid/code     - add one coin to inventory
//   done                  - one-cycle pulse, change fully paid
//   err/short_amount      - one-cycle pulse with unpaid cents
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter logic [3:0] INV_INIT = 4'd15,
  parameter logic [3:0] INV_MAX  = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  output logic       coin_valid,
  output logic [2:0] coin_out,
  input  logic       coin_ack,
  input  logic       refill_valid,
  input  logic [2:0] refill_code,
  output logic       done,
  output logic       err,
  output logic [7:0] short_amount
);

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [2:0] coin_q, coin_d;
  logic       dec_valid;
  logic       empty_5, empty_10, empty_25;

  coin_inventory #(
    .INV_INIT(INV_INIT),
    .INV_MAX (INV_MAX)
  ) u_inv (
    .clk         (clk),
    .rst         (rst),
    .refill_valid(refill_valid),
    .refill_code (refill_code),
    .dec_valid   (dec_valid),
    .dec_code    (coin_q),
    .empty_5     (empty_5),
    .empty_10    (empty_10),
    .empty_25    (empty_25)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      coin_q      <= COIN_NONE;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
    end
  end

  // Outputs are decoded from the state alone, so a reset clears them in
  // the same edge that returns the FSM to IDLE.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_d       = coin_q;
    req_ready    = 1'b0;
    coin_valid   = 1'b0;
    coin_out     = COIN_NONE;
    done         = 1'b0;
    err          = 1'b0;
    short_amount = 8'd0;
    dec_valid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          remaining_d = req_amount;
          if (req_amount == 8'd0) begin
            state_d = ST_DONE;
          end else if ((req_amount % 8'd5) != 8'd0) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_SELECT;
          end
        end
      end

      // Largest coin that fits and is in stock; nothing left to try means
      // the remainder cannot be paid.
      ST_SELECT: begin
        if (remaining_q == 8'd0) begin
          state_d = ST_DONE;
        end else if ((remaining_q >= VAL_25) && !empty_25) begin
          coin_d  = COIN_25;
          state_d = ST_PRESENT;
        end else if ((remaining_q >= VAL_10) && !empty_10) begin
          coin_d  = COIN_10;
          state_d = ST_PRESENT;
        end else if ((remaining_q >= VAL_5) && !empty_5) begin
          coin_d  = COIN_5;
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_ERR;
        end
      end

      ST_PRESENT: begin
        coin_valid = 1'b1;
        coin_out   = coin_q;
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          dec_valid   = 1'b1;
          state_d     = ST_SELECT;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        err          = 1'b1;
        short_amount = remaining_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb_vending_change_dispenser
// Self-checking bench: a table of single requests from a fresh inventory,
// then hand-written sequences for draining, refill, short-change and
// reset-in-PRESENT. Observed coins/done/err are checked against a queue
// of expected events.
module tb_vending_change_dispenser;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       coin_valid;
  logic [2:0] coin_out;
  logic       coin_ack;
  logic       refill_valid;
  logic [2:0] refill_code;
  logic       done;
  logic       err;
  logic [7:0] short_amount;

  always #5 clk = ~clk;

  vending_change_dispenser #(
    .INV_INIT(4'd15),
    .INV_MAX (4'd15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .coin_valid  (coin_valid),
    .coin_out    (coin_out),
    .coin_ack    (coin_ack),
    .refill_valid(refill_valid),
    .refill_code (refill_code),
    .done        (done),
    .err         (err),
    .short_amount(short_amount)
  );

  typedef enum logic [1:0] {EV_COIN, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [2:0] code;
    logic [7:0] short_amt;
  } event_t;

  typedef struct {
    logic [7:0]      amount;
    int              n_coins;
    logic [5:0][2:0] coins;
    logic            is_err;
    logic [7:0]      short_amt;
    logic [3:0]      inv5, inv10, inv25;
  } vec_t;

  event_t exp_q[$];
  vec_t   vecs[7];
  int     n_checks = 0;
  int     n_fail   = 0;

  // Generic compare; every comparison in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // An output event turned up that the scoreboard had no entry for
  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got unexpected event value %0d, expected no event", name, actual);
  endtask

  task automatic pushCoin(input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{kind: EV_COIN, code: code, short_amt: 8'd0});
  endtask

  task automatic pushDone();
    exp_q.push_back('{kind: EV_DONE, code: COIN_NONE, short_amt: 8'd0});
  endtask

  task automatic pushErr(input logic [7:0] short_amt);
    exp_q.push_back('{kind: EV_ERR, code: COIN_NONE, short_amt: short_amt});
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; req_amount = 8'd0;
    coin_ack = 1'b0; refill_valid = 1'b0; refill_code = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic doRefill(input logic [2:0] code);
    @(negedge clk);
    refill_valid = 1'b1; refill_code = code;
    @(negedge clk);
    refill_valid = 1'b0; refill_code = 3'd0;
  endtask

  task automatic checkInventory(input string name, input logic [3:0] e5, input logic [3:0] e10, input logic [3:0] e25);
    checkOutput({name, "_inv5"},  dut.u_inv.cnt_q[0], e5);
    checkOutput({name, "_inv10"}, dut.u_inv.cnt_q[1], e10);
    checkOutput({name, "_inv25"}, dut.u_inv.cnt_q[2], e25);
  endtask

  // Issue one request and act as the coin mechanism until done/err.
  // exp_lat: cycles from accept to first coin_valid/done/err.
  // ack_delay: cycles coin_valid is held before acking.
  // refill_on_ack: refill code pulsed in the same cycle as each ack (0 = none).
  task automatic applyStimulus(input string name, input logic [7:0] amount, input int exp_lat,
                               input int ack_delay, input logic [2:0] refill_on_ack);
    int     cyc, wait_cnt;
    bit     seen_first, finished;
    event_t ev;
    logic [1:0] exp_flags;
    @(negedge clk);
    checkOutput({name, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_amount = amount;
    @(negedge clk);
    req_valid = 1'b0; req_amount = 8'd0;
    cyc = 1; wait_cnt = 0; seen_first = 0; finished = 0;
    while (!finished && cyc < 400) begin
      coin_ack = 1'b0; refill_valid = 1'b0; refill_code = 3'd0;
      if (!seen_first && (coin_valid || done || err)) begin
        seen_first = 1;
        checkOutput({name, "_latency"}, cyc, exp_lat);
      end
      if (coin_valid) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_COIN) begin
          reportUnexpected({name, "_coin"}, coin_out);
          finished = 1;
        end else begin
          checkOutput({name, "_coin_out"}, coin_out, exp_q[0].code);
          if (wait_cnt == ack_delay) begin
            void'(exp_q.pop_front());
            coin_ack = 1'b1;
            if (refill_on_ack != 3'd0) begin
              refill_valid = 1'b1; refill_code = refill_on_ack;
            end
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else if (done || err) begin
        if (exp_q.size() == 0) begin
          reportUnexpected({name, "_done_err"}, {done, err});
        end else begin
          ev = exp_q.pop_front();
          exp_flags = (ev.kind == EV_DONE) ? 2'b10 : (ev.kind == EV_ERR) ? 2'b01 : 2'b00;
          checkOutput({name, "_done_err"}, {done, err}, exp_flags);
          checkOutput({name, "_short"}, short_amount, ev.short_amt);
        end
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    coin_ack = 1'b0; refill_valid = 1'b0; refill_code = 3'd0;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL %s_timeout: got no done/err in %0d cycles, expected completion", name, cyc);
    end
    checkOutput({name, "_done_pulse"}, done, 0);
    checkOutput({name, "_err_pulse"}, err, 0);
    checkOutput({name, "_ready_after"}, req_ready, 1);
    checkOutput({name, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic addVec(input int idx, input logic [7:0] amount, input int n, input logic [5:0][2:0] coins,
                        input logic is_err, input logic [7:0] short_amt,
                        input logic [3:0] i5, input logic [3:0] i10, input logic [3:0] i25);
    vecs[idx].amount    = amount;
    vecs[idx].n_coins   = n;
    vecs[idx].coins     = coins;
    vecs[idx].is_err    = is_err;
    vecs[idx].short_amt = short_amt;
    vecs[idx].inv5      = i5;
    vecs[idx].inv10     = i10;
    vecs[idx].inv25     = i25;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_amount = 8'd0;
    coin_ack = 1'b0; refill_valid = 1'b0; refill_code = 3'd0;

    // Coins listed first-out in the lowest slot
    addVec(0, 8'd40,  3, {3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3}, 1'b0, 8'd0,  4'd14, 4'd14, 4'd14);
    addVec(1, 8'd0,   0, '0,                                   1'b0, 8'd0,  4'd15, 4'd15, 4'd15);
    addVec(2, 8'd37,  0, '0,                                   1'b1, 8'd37, 4'd15, 4'd15, 4'd15);
    addVec(3, 8'd5,   1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1'b0, 8'd0,  4'd14, 4'd15, 4'd15);
    addVec(4, 8'd65,  4, {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3}, 1'b0, 8'd0,  4'd14, 4'd14, 4'd13);
    addVec(5, 8'd100, 4, {3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3}, 1'b0, 8'd0,  4'd15, 4'd15, 4'd11);
    addVec(6, 8'd3,   0, '0,                                   1'b1, 8'd3,  4'd15, 4'd15, 4'd15);

    doReset();
    checkOutput("reset_ready", req_ready, 1);
    checkOutput("reset_coin_valid", coin_valid, 0);
    checkOutput("reset_coin_out", coin_out, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_short", short_amount, 0);
    checkInventory("reset", 4'd15, 4'd15, 4'd15);

    for (int i = 0; i < 7; i++) begin
      doReset();
      for (int k = 0; k < vecs[i].n_coins; k++) pushCoin(vecs[i].coins[k], 1);
      if (vecs[i].is_err) pushErr(vecs[i].short_amt);
      else pushDone();
      applyStimulus($sformatf("vec%0d", i), vecs[i].amount, (vecs[i].n_coins > 0) ? 2 : 1, 0, 3'd0);
      checkInventory($sformatf("vec%0d", i), vecs[i].inv5, vecs[i].inv10, vecs[i].inv25);
    end

    // Drain quarters, then 30c must come out as three dimes
    doReset();
    pushCoin(COIN_25, 10); pushDone();
    applyStimulus("drain25a", 8'd250, 2, 0, 3'd0);
    pushCoin(COIN_25, 5); pushDone();
    applyStimulus("drain25b", 8'd125, 2, 0, 3'd0);
    checkInventory("drained25", 4'd15, 4'd15, 4'd0);
    pushCoin(COIN_10, 3); pushDone();
    applyStimulus("no25_30", 8'd30, 2, 0, 3'd0);
    checkInventory("no25_30", 4'd15, 4'd12, 4'd0);

    // Refill: valid codes add one, invalid codes do nothing, saturation
    doRefill(3'd3);
    doRefill(3'd0);
    doRefill(3'd5);
    doRefill(3'd7);
    checkInventory("refill", 4'd15, 4'd12, 4'd1);
    for (int k = 0; k < 5; k++) doRefill(3'd2);
    doRefill(3'd1);
    checkInventory("refill_sat", 4'd15, 4'd15, 4'd1);

    // Refill and ack on the same denomination cancel; on different ones both apply
    pushCoin(COIN_25, 1); pushDone();
    applyStimulus("ack_refill_same", 8'd25, 2, 0, 3'd3);
    checkInventory("ack_refill_same", 4'd15, 4'd15, 4'd1);
    pushCoin(COIN_10, 1); pushDone();
    applyStimulus("ack_refill_other", 8'd10, 2, 0, 3'd3);
    checkInventory("ack_refill_other", 4'd15, 4'd14, 4'd2);

    // Only one nickel left: 50c pays 5c then reports 45c short
    doReset();
    pushCoin(COIN_25, 10); pushDone();
    applyStimulus("short_q1", 8'd250, 2, 0, 3'd0);
    pushCoin(COIN_25, 5); pushDone();
    applyStimulus("short_q2", 8'd125, 2, 0, 3'd0);
    pushCoin(COIN_10, 15); pushDone();
    applyStimulus("short_d", 8'd150, 2, 0, 3'd0);
    pushCoin(COIN_5, 14); pushDone();
    applyStimulus("short_n", 8'd70, 2, 0, 3'd0);
    checkInventory("one_nickel", 4'd1, 4'd0, 4'd0);
    pushCoin(COIN_5, 1); pushErr(8'd45);
    applyStimulus("short50", 8'd50, 2, 0, 3'd0);
    checkInventory("short50", 4'd0, 4'd0, 4'd0);
    pushErr(8'd5);
    applyStimulus("empty5", 8'd5, 2, 0, 3'd0);
    checkInventory("empty5", 4'd0, 4'd0, 4'd0);

    // Slow ack holds coin_out; req_valid ignored; reset in PRESENT aborts
    doReset();
    @(negedge clk);
    req_valid = 1'b1; req_amount = 8'd40;
    @(negedge clk);
    req_valid = 1'b0; req_amount = 8'd0;
    checkOutput("slow_select_valid", coin_valid, 0);
    @(negedge clk);
    checkOutput("slow_first_valid", coin_valid, 1);
    checkOutput("slow_first_coin", coin_out, COIN_25);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_amount = 8'd5; coin_ack = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("slow_hold%0d_valid", k), coin_valid, 1);
      checkOutput($sformatf("slow_hold%0d_coin", k), coin_out, COIN_25);
      checkOutput($sformatf("slow_hold%0d_ready", k), req_ready, 0);
    end
    req_valid = 1'b0; req_amount = 8'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_coin_valid", coin_valid, 0);
    checkOutput("abort_coin_out", coin_out, 0);
    checkOutput("abort_ready", req_ready, 1);
    checkInventory("abort", 4'd15, 4'd15, 4'd15);
    for (int k = 0; k < 4; k++) begin
      coin_ack = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("abort_idle%0d_done", k), done, 0);
      checkOutput($sformatf("abort_idle%0d_err", k), err, 0);
      checkOutput($sformatf("abort_idle%0d_valid", k), coin_valid, 0);
    end
    coin_ack = 1'b0;
    checkInventory("stray_ack", 4'd15, 4'd15, 4'd15);
    pushCoin(COIN_5, 1); pushDone();
    applyStimulus("after_abort", 8'd5, 2, 0, 3'd0);
    checkInventory("after_abort", 4'd14, 4'd15, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
